// File: rtl/bldc_cfg_status_regs_v2_if.sv
// Register bus between the Wishbone slave adapter and the BLDC register file.
interface bldc_cfg_status_regs_v2_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              wen_i;
  logic              ren_i;
  logic [DATA_W-1:0] rdata_o;

  modport master (output addr_i, wdata_i, wen_i, ren_i, input rdata_o);
  modport slave  (input addr_i, wdata_i, wen_i, ren_i, output rdata_o);
endinterface

// File: rtl/bldc_cfg_status_regs_v2.sv
// BLDC register file: shadowed PWM timing, ADC capture with overrun, sticky W1C interrupts.
// Optional BLDC_HALL_TS_EN adds the hall interval timestamp register at 0x1C.
module bldc_cfg_status_regs_v2 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NCH    = 3,
  parameter int unsigned ADC_W  = 12,
  parameter int unsigned PWM_W  = 12,
  parameter int unsigned HALL_W = 3,
  parameter int unsigned TS_W   = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bldc_cfg_status_regs_v2_if.slave bus,
  output logic                   pwm_en_o,
  output logic                   adc_en_o,
  output logic [PWM_W-1:0]       pwm_period_o,
  output logic [PWM_W-1:0]       pwm_duty_o,
  output logic [2:0]             comm_o,
  output logic                   bldc_int_o,
  input  logic                   pwm_sync_i,
  input  logic [NCH-1:0]         adc_valid_i,
  input  logic [NCH*ADC_W-1:0]   adc_data_i,
  input  logic [HALL_W-1:0]      hall_value_i,
  input  logic                   hall_int_i
);
  localparam int unsigned NB = NCH + 2;

  logic [PWM_W-1:0]  r_per_sh, r_duty_sh, r_per, r_duty;
  logic              r_pend, r_pwm_en, r_adc_en, r_hall_d, r_int;
  logic [2:0]        r_comm;
  logic [HALL_W-1:0] r_hsv;
  logic [NB-1:0]     r_isr, r_ier;
  logic [ADC_W-1:0]  r_adc [NCH];
  logic [NCH-1:0]    r_unread, r_ovr;
  logic [DATA_W-1:0] r_rdata;

  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_a;
  logic              w_wr_ppr, w_wr_pdcr, w_wr_ccr, w_wr_bier, w_apply, w_hall_ev;
  logic [NB-1:0]     w_clr, w_ev;
  logic [NCH-1:0]    w_ch_rd, w_cap;
  logic [DATA_W-1:0] w_rd;
  logic              w_unused;

  assign w_addr    = bus.addr_i;
  assign w_a       = w_addr[7:0];
  assign w_wr_ppr  = bus.wen_i && (w_a == 8'h00);
  assign w_wr_pdcr = bus.wen_i && (w_a == 8'h04);
  assign w_wr_ccr  = bus.wen_i && (w_a == 8'h0C);
  assign w_wr_bier = bus.wen_i && (w_a == 8'h14);
  assign w_clr     = (bus.wen_i && (w_a == 8'h18)) ? bus.wdata_i[NB-1:0] : '0;
  assign w_hall_ev = hall_int_i & ~r_hall_d;
  assign w_ev      = {adc_valid_i, pwm_sync_i, w_hall_ev};
  assign w_cap     = adc_valid_i & {NCH{r_adc_en}};
  // Shadow goes live at the period boundary, or right away while the PWM is stopped.
  assign w_apply   = r_pend && (pwm_sync_i || !r_pwm_en);
  assign w_unused  = ^{w_addr[ADDR_W-1:8], bus.wdata_i, {TS_W{1'b0}}};

  assign bus.rdata_o  = r_rdata;
  assign pwm_en_o     = r_pwm_en;
  assign adc_en_o     = r_adc_en;
  assign pwm_period_o = r_per;
  assign pwm_duty_o   = r_duty;
  assign comm_o       = r_comm;
  assign bldc_int_o   = r_int;

`ifdef BLDC_HALL_TS_EN
  logic [TS_W-1:0] r_ts, r_htsr;

  // Free-running interval counter, restarted at 1 by each hall event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ts   <= '0;
      r_htsr <= '0;
    end else if (w_hall_ev) begin
      r_htsr <= r_ts;
      r_ts   <= TS_W'(1);
    end else if (r_ts != '1) begin
      r_ts <= r_ts + TS_W'(1);
    end
  end
`endif

  // Read decode and per-channel read hits.
  always_comb begin
    w_rd    = '0;
    w_ch_rd = '0;
    for (int i = 0; i < NCH; i++) w_ch_rd[i] = bus.ren_i && (w_a == 8'(32 + 4 * i));
    case (w_a)
      8'h00: begin
        w_rd[PWM_W-1:0]  = r_per_sh;
        w_rd[16 +: PWM_W] = r_duty_sh;
      end
      8'h04: begin
        w_rd[0]  = r_pwm_en;
        w_rd[1]  = r_adc_en;
        w_rd[31] = r_pend;
      end
      8'h08: w_rd[HALL_W-1:0] = r_hsv;
      8'h0C: w_rd[2:0] = r_comm;
      8'h10: w_rd[NB-1:0] = r_isr;
      8'h14: w_rd[NB-1:0] = r_ier;
`ifdef BLDC_HALL_TS_EN
      8'h1C: w_rd[TS_W-1:0] = r_htsr;
`endif
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (w_a == 8'(32 + 4 * i)) begin
            w_rd[ADC_W-1:0] = r_adc[i];
            w_rd[15]        = r_ovr[i];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_per_sh  <= '0;
      r_duty_sh <= '0;
      r_per     <= '0;
      r_duty    <= '0;
      r_pend    <= 1'b0;
      r_pwm_en  <= 1'b0;
      r_adc_en  <= 1'b0;
      r_hall_d  <= 1'b0;
      r_int     <= 1'b0;
      r_comm    <= '0;
      r_hsv     <= '0;
      r_isr     <= '0;
      r_ier     <= '0;
      r_unread  <= '0;
      r_ovr     <= '0;
      r_rdata   <= '0;
      for (int i = 0; i < NCH; i++) r_adc[i] <= '0;
    end else begin
      r_hall_d <= hall_int_i;
      r_hsv    <= hall_value_i;
      if (w_wr_ppr) begin
        r_per_sh  <= bus.wdata_i[PWM_W-1:0];
        r_duty_sh <= bus.wdata_i[16 +: PWM_W];
      end
      if (w_apply) begin
        r_per  <= r_per_sh;
        r_duty <= r_duty_sh;
      end
      r_pend <= w_wr_ppr | (r_pend & ~w_apply);
      if (w_wr_pdcr) begin
        r_pwm_en <= bus.wdata_i[0];
        r_adc_en <= bus.wdata_i[1];
      end
      if (w_wr_ccr)  r_comm <= bus.wdata_i[2:0];
      if (w_wr_bier) r_ier  <= bus.wdata_i[NB-1:0];
      // Set beats clear when both hit the same bit in one cycle.
      r_isr <= (r_isr & ~w_clr) | w_ev;
      r_int <= |(r_isr & r_ier);
      for (int i = 0; i < NCH; i++) begin
        if (w_cap[i]) r_adc[i] <= adc_data_i[i*ADC_W +: ADC_W];
      end
      r_unread <= w_cap | (r_unread & ~w_ch_rd);
      r_ovr    <= ~w_ch_rd & (r_ovr | (w_cap & r_unread));
      r_rdata  <= bus.ren_i ? w_rd : '0;
    end
  end
endmodule

// File: tb/tb_bldc_cfg_status_regs_v2.sv
// Self-checking bench for bldc_cfg_status_regs_v2: vector table, directed corners, random vs model.
module tb_bldc_cfg_status_regs_v2;
  localparam int unsigned NCH = 3, ADC_W = 12, PWM_W = 12, HALL_W = 3, NB = NCH + 2;
  localparam int unsigned MASK = (1 << NB) - 1;

  logic clk = 1'b0;
  logic rst_n, pwm_sync, hall_int, pwm_en, adc_en, bint;
  logic [NCH-1:0] adc_valid;
  logic [NCH*ADC_W-1:0] adc_data;
  logic [HALL_W-1:0] hall_value;
  logic [PWM_W-1:0] period, duty;
  logic [2:0] comm;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  bldc_cfg_status_regs_v2_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  bldc_cfg_status_regs_v2 dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .pwm_en_o(pwm_en), .adc_en_o(adc_en), .pwm_period_o(period), .pwm_duty_o(duty),
    .comm_o(comm), .bldc_int_o(bint), .pwm_sync_i(pwm_sync), .adc_valid_i(adc_valid),
    .adc_data_i(adc_data), .hall_value_i(hall_value), .hall_int_i(hall_int)
  );

  typedef struct {
    logic [7:0]  a;
    logic        dowr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];

  // Reference model state for the random phase.
  int unsigned m_isr, m_ier, m_samp[NCH];
  bit m_int, m_adc_en, m_hall_prev, m_unread[NCH], m_ovr[NCH];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.addr_i = 32'(a); bus.wdata_i = d; bus.wen_i = 1'b1;
    tick();
    bus.wen_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.addr_i = 32'(a); bus.ren_i = 1'b1;
    tick();
    bus.ren_i = 1'b0;
    d = bus.rdata_o;
  endtask

  function automatic int unsigned model_read(input logic [7:0] a);
    if (a == 8'h10) return m_isr;
    if (a == 8'h14) return m_ier;
    for (int c = 0; c < NCH; c++)
      if (a == 8'(32 + 4 * c)) return (m_ovr[c] ? 32'h8000 : 32'h0) | m_samp[c];
    return 0;
  endfunction

  initial begin
    logic [31:0] d;
    tbl[0]  = '{8'h0C, 1'b1, 32'h0000_0005, 32'h0000_0005};
    tbl[1]  = '{8'h0C, 1'b1, 32'h0000_00FF, 32'h0000_0007};
    tbl[2]  = '{8'h14, 1'b1, 32'hFFFF_FFFF, 32'h0000_001F};
    tbl[3]  = '{8'h14, 1'b1, 32'h0000_0000, 32'h0000_0000};
    tbl[4]  = '{8'h04, 1'b1, 32'hFFFF_FFFF, 32'h0000_0003};
    tbl[5]  = '{8'h04, 1'b1, 32'h0000_0000, 32'h0000_0000};
    tbl[6]  = '{8'h18, 1'b1, 32'h0000_00FF, 32'h0000_0000};
    tbl[7]  = '{8'h10, 1'b1, 32'h0000_00FF, 32'h0000_0000};
    tbl[8]  = '{8'h40, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[9]  = '{8'h2C, 1'b1, 32'h0000_0001, 32'h0000_0000};
    tbl[10] = '{8'h0C, 1'b0, 32'h0000_0000, 32'h0000_0007};
    tbl[11] = '{8'h00, 1'b1, 32'hFFFF_FABC, 32'h0FFF_0ABC};
    tbl[12] = '{8'h1C, 1'b1, 32'h0000_0005, 32'h0000_0000};

    bus.addr_i = '0; bus.wdata_i = '0; bus.wen_i = 1'b0; bus.ren_i = 1'b0;
    rst_n = 1'b0; pwm_sync = 1'b0; hall_int = 1'b0; adc_valid = '0; adc_data = '0;
    hall_value = '0;

    // Reset
    tick(); tick();
    check("reset_outputs", 32'({pwm_en, adc_en, period, duty, comm, bint}), 32'h0);
    check("reset_rdata", bus.rdata_o, 32'h0);
    rst_n = 1'b1;
    for (int a = 0; a < 64; a += 4) begin
      rd(8'(a), d);
      check($sformatf("reset_read_%02h", a), d, 32'h0);
    end

    // Register table
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].dowr) wr(tbl[i].a, tbl[i].wd);
      rd(tbl[i].a, d);
      check($sformatf("table_%0d_addr_%02h", i, tbl[i].a), d, tbl[i].exp);
    end
    check("comm_out", 32'(comm), 32'h7);
    tick();
    check("rdata_zero_after_idle", bus.rdata_o, 32'h0);

    // PPR shadowing
    wr(8'h04, 32'h1);
    wr(8'h00, 32'h0320_03E8);
    check("ppr_period_held", 32'(period), 32'hABC);
    rd(8'h04, d);
    check("ppr_pending_set", d, 32'h8000_0001);
    pwm_sync = 1'b1; tick(); pwm_sync = 1'b0;
    check("ppr_period_applied", 32'(period), 32'h3E8);
    check("ppr_duty_applied", 32'(duty), 32'h320);
    rd(8'h04, d);
    check("ppr_pending_clr", d, 32'h0000_0001);
    pwm_sync = 1'b1; wr(8'h00, 32'h0001_0002); pwm_sync = 1'b0;
    check("ppr_sync_write_held", 32'(period), 32'h3E8);
    rd(8'h00, d);
    check("ppr_read_shadow", d, 32'h0001_0002);
    pwm_sync = 1'b1; tick(); pwm_sync = 1'b0;
    check("ppr_sync_write_applied", 32'({duty, period}), 32'h0010_02);

    // Hall interrupt, W1C, set-beats-clear
    wr(8'h18, 32'h1F); wr(8'h14, 32'h1);
    hall_int = 1'b1; tick();
    check("int_one_clk_after_edge", 32'(bint), 32'h0);
    tick();
    check("int_two_clk_after_edge", 32'(bint), 32'h1);
    rd(8'h10, d);
    check("bisr_hall", d, 32'h1);
    hall_int = 1'b0;
    wr(8'h18, 32'h1);
    check("int_one_clk_after_clr", 32'(bint), 32'h1);
    tick();
    check("int_two_clk_after_clr", 32'(bint), 32'h0);
    hall_int = 1'b1; tick(); hall_int = 1'b0; tick();
    hall_int = 1'b1; wr(8'h18, 32'h1); hall_int = 1'b0;
    rd(8'h10, d);
    check("bisr_set_beats_clr", d, 32'h1);
    check("int_set_beats_clr", 32'(bint), 32'h1);

    // HSVR
    hall_value = 3'd5; tick();
    rd(8'h08, d);
    check("hsvr", d, 32'h5);

    // ADC overrun and enable gating
    wr(8'h04, 32'h2);
    adc_valid = 3'b100; adc_data[2*ADC_W +: ADC_W] = 12'hABC; tick();
    adc_data[2*ADC_W +: ADC_W] = 12'h123; tick();
    adc_valid = '0;
    rd(8'h28, d);
    check("ac2dr_overrun", d, 32'h8123);
    rd(8'h28, d);
    check("ac2dr_ovr_cleared", d, 32'h0123);
    wr(8'h04, 32'h0);
    adc_valid = 3'b001; adc_data[0 +: ADC_W] = 12'h555; tick(); adc_valid = '0;
    rd(8'h20, d);
    check("ac0dr_adc_disabled", d, 32'h0);

    // Hall interval timestamp
    hall_int = 1'b1; tick(); hall_int = 1'b0;
    repeat (99) tick();
    hall_int = 1'b1; tick(); hall_int = 1'b0;
    rd(8'h1C, d);
`ifdef BLDC_HALL_TS_EN
    check("htsr_interval", d, 32'd100);
`else
    check("htsr_absent", d, 32'd0);
`endif

    // Reset mid-operation drops pending shadow and interrupt
    wr(8'h04, 32'h1); wr(8'h14, 32'h1F); wr(8'h00, 32'h0005_0006);
    pwm_sync = 1'b1; tick(); pwm_sync = 1'b0; tick();
    check("int_before_reset", 32'(bint), 32'h1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("int_after_reset", 32'(bint), 32'h0);
    check("outs_after_reset", 32'({pwm_en, period, duty}), 32'h0);
    rd(8'h04, d);
    check("pdcr_after_reset", d, 32'h0);

    // Random phase vs model
    m_isr = 0; m_ier = 0; m_int = 0; m_adc_en = 1; m_hall_prev = 0;
    for (int c = 0; c < NCH; c++) begin m_samp[c] = 0; m_unread[c] = 0; m_ovr[c] = 0; end
    wr(8'h04, 32'h2);
    for (int n = 0; n < 1500; n++) begin
      int unsigned op, ev, clr, wd, valid, dat[NCH];
      logic [7:0] a;
      int unsigned exp_rd;
      valid = ($urandom % 3 == 0) ? ($urandom % 8) : 0;
      for (int c = 0; c < NCH; c++) dat[c] = $urandom % 4096;
      if ($urandom % 4 == 0) hall_int = ~hall_int;
      pwm_sync = ($urandom % 8 == 0);
      op = $urandom % 10;
      wd = $urandom;
      a = 8'h00;
      if (op <= 2) a = 8'(32 + 4 * ($urandom % 4));
      else if (op == 3) a = 8'h10;
      else if (op == 7) a = 8'h14;
      else if (op == 4) a = 8'h18;
      else if (op == 5) a = 8'h14;
      else if (op == 6) a = 8'h04;

      exp_rd = (op <= 3 || op == 7) ? model_read(a) : 0;
      ev = ((hall_int && !m_hall_prev) ? 1 : 0) | (pwm_sync ? 2 : 0) | (valid << 2);
      clr = (op == 4) ? (wd & MASK) : 0;
      m_int = (m_isr & m_ier) != 0;
      m_isr = ((m_isr & ~clr) | ev) & MASK;
      if (op == 5) m_ier = wd & MASK;
      for (int c = 0; c < NCH; c++) begin
        bit hit, cap;
        hit = (op <= 2) && (a == 8'(32 + 4 * c));
        cap = valid[c] && m_adc_en;
        if (hit) m_ovr[c] = 0;
        if (cap) begin
          if (m_unread[c] && !hit) m_ovr[c] = 1;
          m_samp[c] = dat[c];
          m_unread[c] = 1;
        end else if (hit) m_unread[c] = 0;
      end
      if (op == 6) m_adc_en = wd[1];
      m_hall_prev = hall_int;

      adc_valid = NCH'(valid);
      for (int c = 0; c < NCH; c++) adc_data[c*ADC_W +: ADC_W] = ADC_W'(dat[c]);
      bus.addr_i = 32'(a); bus.wdata_i = wd;
      bus.ren_i = (op <= 3 || op == 7);
      bus.wen_i = (op >= 4 && op <= 6);
      tick();
      bus.ren_i = 1'b0; bus.wen_i = 1'b0;
      check($sformatf("rand_%0d_rdata_%02h", n, a), bus.rdata_o, exp_rd);
      check($sformatf("rand_%0d_int", n), 32'(bint), 32'(m_int));
    end
    adc_valid = '0; pwm_sync = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
